aes_block_loader: RTL and testbench

//  Upstream feeder for the AES encoder stage: builds a 128-bit key and a 128-bit plaintext

---
 rtl/aes_io_pkg.sv | 21 ++
 rtl/byte_buffer.sv | 44 ++++
 rtl/aes_block_loader.sv | 157 +++++++++++++++
 tb/tb_aes_block_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_io_pkg.sv
// Shared constants, FSM state encoding and byte-lane helper for the AES block loader.
// Byte 0 of a block always occupies the most significant lane.
package aes_io_pkg;

  localparam int NBYTES = 16;
  localparam int BYTE_W = 8;

  localparam logic EDIT = 1'b0;
  localparam logic HOLD = 1'b1;

  typedef enum logic {
    ST_EDIT = EDIT,
    ST_HOLD = HOLD
  } state_t;

  // MSB index of byte i inside a flat block of nbytes x byte_w bits.
  function automatic int byte_slice(input int i, input int nbytes, input int byte_w);
    return nbytes * byte_w - 1 - byte_w * i;
  endfunction

endpackage

// File: rtl/byte_buffer.sv
// NB x BW register file with per-byte written flags, one write port, one read port
// and a flat view (byte 0 in the top lane). Mask clear leaves byte contents intact.
module byte_buffer
  import aes_io_pkg::*;
#(
  parameter int NB = 16,
  parameter int BW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_we,
  input  logic [$clog2(NB)-1:0]  i_waddr,
  input  logic [BW-1:0]          i_wdata,
  input  logic                   i_mask_clr,
  input  logic [$clog2(NB)-1:0]  i_raddr,
  output logic [BW-1:0]          o_rdata,
  output logic [NB*BW-1:0]       o_flat,
  output logic [NB-1:0]          o_mask
);

  logic [BW-1:0] r_mem [NB];
  logic [NB-1:0] r_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) r_mem[i] <= '0;
      r_mask <= '0;
    end else begin
      if (i_mask_clr) r_mask <= '0;
      if (i_we) begin
        r_mem[i_waddr]  <= i_wdata;
        r_mask[i_waddr] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_flat
    assign o_flat[byte_slice(g, NB, BW) -: BW] = r_mem[g];
  end

  assign o_rdata = r_mem[i_raddr];
  assign o_mask  = r_mask;

endmodule

// File: rtl/aes_block_loader.sv
// Builds key and plaintext byte-by-byte from button pulses and hands {key, text}
// to the AES encoder over valid/ready once both buffers are complete.
module aes_block_loader #(
  parameter int NBYTES = aes_io_pkg::NBYTES,
  parameter int BYTE_W = aes_io_pkg::BYTE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BYTE_W-1:0]          sw_byte,
  input  logic                       sel_key,
  input  logic                       p_write,
  input  logic                       p_commit,
  input  logic                       p_left,
  input  logic                       p_right,
  input  logic                       blk_ready,
  output logic                       blk_valid,
  output logic [NBYTES*BYTE_W-1:0]   key_out,
  output logic [NBYTES*BYTE_W-1:0]   text_out,
  output logic [$clog2(NBYTES)-1:0]  cursor,
  output logic [BYTE_W-1:0]          cur_byte,
  output logic [NBYTES-1:0]          fill_mask,
  output logic                       busy,
  output logic                       err
);
  import aes_io_pkg::*;

  localparam int CW    = $clog2(NBYTES);
  localparam int BLK_W = NBYTES * BYTE_W;

  // Handshake: a block transfers on any clock edge where blk_valid & blk_ready;
  // once raised, blk_valid and the block stay fixed until that edge.

  state_t             r_state;
  logic               r_blk_valid;
  logic               r_busy;
  logic               r_err;
  logic [BLK_W-1:0]   r_key_out;
  logic [BLK_W-1:0]   r_text_out;
  logic [CW-1:0]      r_cursor;
  logic [BYTE_W-1:0]  r_cur_byte;
  logic [NBYTES-1:0]  r_fill_mask;

  logic               w_do_commit;
  logic               w_do_write;
  logic               w_do_left;
  logic               w_do_right;
  logic               w_key_we;
  logic               w_text_we;
  logic               w_accept;
  logic               w_full;
  logic [BLK_W-1:0]   w_key_flat;
  logic [BLK_W-1:0]   w_text_flat;
  logic [NBYTES-1:0]  w_key_mask;
  logic [NBYTES-1:0]  w_text_mask;
  logic [BYTE_W-1:0]  w_key_rd;
  logic [BYTE_W-1:0]  w_text_rd;

  // One action per EDIT cycle: commit > write > left > right.
  always_comb begin
    w_do_commit = 1'b0;
    w_do_write  = 1'b0;
    w_do_left   = 1'b0;
    w_do_right  = 1'b0;
    if (r_state == ST_EDIT) begin
      w_do_commit = p_commit;
      w_do_write  = !p_commit && p_write;
      w_do_left   = !p_commit && !p_write && p_left;
      w_do_right  = !p_commit && !p_write && !p_left && p_right;
    end
    w_key_we  = w_do_write && sel_key;
    w_text_we = w_do_write && !sel_key;
    w_accept  = (r_state == ST_HOLD) && r_blk_valid && blk_ready;
    w_full    = (&w_key_mask) && (&w_text_mask);
  end

  byte_buffer #(.NB(NBYTES), .BW(BYTE_W)) u_key_buf (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_key_we),
    .i_waddr    (r_cursor),
    .i_wdata    (sw_byte),
    .i_mask_clr (1'b0),
    .i_raddr    (r_cursor),
    .o_rdata    (w_key_rd),
    .o_flat     (w_key_flat),
    .o_mask     (w_key_mask)
  );

  // Text mask is cleared on hand-off so a fresh plaintext must be entered.
  byte_buffer #(.NB(NBYTES), .BW(BYTE_W)) u_text_buf (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_text_we),
    .i_waddr    (r_cursor),
    .i_wdata    (sw_byte),
    .i_mask_clr (w_accept),
    .i_raddr    (r_cursor),
    .o_rdata    (w_text_rd),
    .o_flat     (w_text_flat),
    .o_mask     (w_text_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EDIT;
      r_blk_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_key_out   <= '0;
      r_text_out  <= '0;
      r_cursor    <= '0;
      r_cur_byte  <= '0;
      r_fill_mask <= '0;
    end else begin
      r_err       <= 1'b0;
      r_cur_byte  <= sel_key ? w_key_rd : w_text_rd;
      r_fill_mask <= sel_key ? w_key_mask : w_text_mask;
      case (r_state)
        ST_EDIT: begin
          if (w_do_commit) begin
            if (w_full) begin
              r_key_out   <= w_key_flat;
              r_text_out  <= w_text_flat;
              r_blk_valid <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= ST_HOLD;
            end else begin
              r_err <= 1'b1;
            end
          end else if (w_do_write || w_do_right) begin
            r_cursor <= r_cursor + CW'(1);
          end else if (w_do_left) begin
            r_cursor <= r_cursor - CW'(1);
          end
        end
        ST_HOLD: begin
          if (w_accept) begin
            r_blk_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_EDIT;
          end
        end
        default: r_state <= ST_EDIT;
      endcase
    end
  end

  assign blk_valid = r_blk_valid;
  assign key_out   = r_key_out;
  assign text_out  = r_text_out;
  assign cursor    = r_cursor;
  assign cur_byte  = r_cur_byte;
  assign fill_mask = r_fill_mask;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader: a table of single-cycle pulse vectors plus
// hand-written sequences for commit, hold, hand-off, key reuse and reset-in-hold.
module tb_aes_block_loader;

  logic         clk;
  logic         rst;
  logic [7:0]   sw_byte;
  logic         sel_key;
  logic         p_write;
  logic         p_commit;
  logic         p_left;
  logic         p_right;
  logic         blk_ready;
  logic         blk_valid;
  logic [127:0] key_out;
  logic [127:0] text_out;
  logic [3:0]   cursor;
  logic [7:0]   cur_byte;
  logic [15:0]  fill_mask;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q[$];
  logic [7:0]   key_b[16];
  logic [7:0]   text_b[16];
  logic [127:0] exp_key;
  logic [127:0] exp_text;

  aes_block_loader dut (
    .clk       (clk),
    .rst       (rst),
    .sw_byte   (sw_byte),
    .sel_key   (sel_key),
    .p_write   (p_write),
    .p_commit  (p_commit),
    .p_left    (p_left),
    .p_right   (p_right),
    .blk_ready (blk_ready),
    .blk_valid (blk_valid),
    .key_out   (key_out),
    .text_out  (text_out),
    .cursor    (cursor),
    .cur_byte  (cur_byte),
    .fill_mask (fill_mask),
    .busy      (busy),
    .err       (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    p_write = 0; p_commit = 0; p_left = 0; p_right = 0;
    blk_ready = 0; sel_key = 0; sw_byte = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [7:0] b[16]);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r;
  endfunction

  // ---------------- drivers ----------------
  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic step(input logic c, input logic w, input logic l, input logic r,
                      input logic s, input logic [7:0] sw, input logic rdy);
    p_commit = c; p_write = w; p_left = l; p_right = r;
    sel_key = s; sw_byte = sw; blk_ready = rdy;
    @(negedge clk);
    p_commit = 0; p_write = 0; p_left = 0; p_right = 0; blk_ready = 0;
  endtask

  task automatic idle(input int n, input logic s);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, s, sw_byte, 0);
  endtask

  task automatic commit_and_expect_hold(input string tag);
    exp_key  = pack(key_b);
    exp_text = pack(text_b);
    exp_q.push_back({exp_key, exp_text});
    step(1, 0, 0, 0, 0, 8'h00, 0);
    check({tag, "_valid"}, blk_valid, 1'b1);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_key"}, key_out, exp_key);
    check({tag, "_text"}, text_out, exp_text);
  endtask

  task automatic accept(input string tag);
    logic [255:0] exp_blk;
    check({tag, "_valid_before"}, blk_valid, 1'b1);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue: got empty expected one block", tag);
    end else begin
      exp_blk = exp_q.pop_front();
      check({tag, "_block"}, {key_out, text_out}, exp_blk);
    end
    step(0, 0, 0, 0, 0, 8'h00, 1);
    check({tag, "_valid_after"}, blk_valid, 1'b0);
    check({tag, "_busy_after"}, busy, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       c, w, l, r, s;
    logic [7:0] sw;
    logic       rdy;
    logic [3:0] exp_cursor;
    logic       exp_err;
    logic       exp_valid;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic w, input logic l, input logic r,
                              input logic s, input logic [7:0] sw, input logic rdy,
                              input logic [3:0] cur, input logic e, input logic v);
    vec_t t;
    t.c = c; t.w = w; t.l = l; t.r = r; t.s = s; t.sw = sw; t.rdy = rdy;
    t.exp_cursor = cur; t.exp_err = e; t.exp_valid = v;
    return t;
  endfunction

  vec_t vecs[8];

  initial begin
    //                c  w  l  r  s  sw     rdy cur  err val
    vecs[0] = mk(0, 0, 1, 0, 0, 8'h00, 0, 4'd15, 0, 0); // 0 - 1 wraps to 15
    vecs[1] = mk(0, 0, 0, 1, 0, 8'h00, 0, 4'd0,  0, 0); // 15 + 1 wraps to 0
    vecs[2] = mk(0, 0, 0, 1, 0, 8'h00, 0, 4'd1,  0, 0);
    vecs[3] = mk(0, 0, 1, 1, 0, 8'h00, 0, 4'd0,  0, 0); // left beats right
    vecs[4] = mk(0, 1, 1, 0, 0, 8'hAA, 0, 4'd1,  0, 0); // write beats left
    vecs[5] = mk(1, 1, 0, 0, 0, 8'h55, 0, 4'd1,  1, 0); // commit beats write, refused
    vecs[6] = mk(0, 0, 0, 0, 0, 8'h00, 1, 4'd1,  0, 0); // ready in EDIT is inert
    vecs[7] = mk(0, 0, 1, 0, 0, 8'h00, 0, 4'd0,  0, 0);

    @(negedge clk);
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_valid", blk_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cursor", cursor, 4'd0);
    check("rst_cur_byte", cur_byte, 8'h00);
    check("rst_fill_mask", fill_mask, 16'h0000);
    check("rst_key", key_out, 128'h0);
    check("rst_text", text_out, 128'h0);
    rst = 1'b0;

    // Priority and cursor wrap table.
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].c, vecs[i].w, vecs[i].l, vecs[i].r, vecs[i].s, vecs[i].sw, vecs[i].rdy);
      check($sformatf("vec%0d_cursor", i), cursor, vecs[i].exp_cursor);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("vec%0d_valid", i), blk_valid, vecs[i].exp_valid);
    end
    idle(1, 0);
    check("tbl_cur_byte", cur_byte, 8'hAA);
    check("tbl_text_mask", fill_mask, 16'h0001);
    idle(1, 1);
    check("tbl_sel_key_mask", fill_mask, 16'h0000);

    // Fill key 00..0F; cursor wraps to 0.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      key_b[i] = 8'(i);
      step(0, 1, 0, 0, 1, key_b[i], 0);
    end
    check("key_fill_cursor", cursor, 4'd0);
    check("key_fill_err", err, 1'b0);
    idle(1, 1);
    check("key_fill_mask", fill_mask, 16'hFFFF);
    step(0, 0, 0, 1, 1, 8'h00, 0);
    idle(1, 1);
    check("key_cur_byte1", cur_byte, 8'h01);
    step(0, 0, 1, 0, 1, 8'h00, 0);

    // Text only 15 bytes: commit refused with a one-cycle err.
    for (int i = 0; i < 15; i++) begin
      text_b[i] = {4'(i), 4'(i)};
      step(0, 1, 0, 0, 0, text_b[i], 0);
    end
    check("part_cursor", cursor, 4'd15);
    step(1, 0, 0, 0, 0, 8'h00, 0);
    check("part_err", err, 1'b1);
    check("part_valid", blk_valid, 1'b0);
    check("part_busy", busy, 1'b0);
    idle(1, 0);
    check("part_err_clear", err, 1'b0);
    check("part_text_mask", fill_mask, 16'h7FFF);

    // Complete text, commit, hold for 5 cycles with pulses ignored.
    text_b[15] = 8'hFF;
    step(0, 1, 0, 0, 0, text_b[15], 0);
    commit_and_expect_hold("hold");
    for (int i = 0; i < 5; i++) begin
      step(i == 2, 1, i == 3, i == 4, 0, 8'h77, 0);
      check($sformatf("hold%0d_valid", i), blk_valid, 1'b1);
      check($sformatf("hold%0d_err", i), err, 1'b0);
      check($sformatf("hold%0d_cursor", i), cursor, 4'd0);
      check($sformatf("hold%0d_key", i), key_out, exp_key);
      check($sformatf("hold%0d_text", i), text_out, exp_text);
    end
    accept("acc1");
    idle(1, 0);
    check("acc1_text_mask", fill_mask, 16'h0000);
    check("acc1_text_byte0", cur_byte, 8'h00);
    idle(1, 1);
    check("acc1_key_mask", fill_mask, 16'hFFFF);

    // New text reusing the stored key.
    for (int i = 0; i < 16; i++) begin
      text_b[i] = 8'hA0 + 8'(i);
      step(0, 1, 0, 0, 0, text_b[i], 0);
    end
    commit_and_expect_hold("reuse");
    check("reuse_key_same", key_out, 128'h000102030405060708090A0B0C0D0E0F);
    accept("acc2");

    // Reset while holding.
    for (int i = 0; i < 16; i++) begin
      text_b[i] = 8'hC0 + 8'(i);
      step(0, 1, 0, 0, 0, text_b[i], 0);
    end
    commit_and_expect_hold("prerst");
    void'(exp_q.pop_back());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("hrst_valid", blk_valid, 1'b0);
    check("hrst_busy", busy, 1'b0);
    check("hrst_cursor", cursor, 4'd0);
    check("hrst_key", key_out, 128'h0);
    check("hrst_mask", fill_mask, 16'h0000);
    idle(1, 1);
    check("hrst_key_mask", fill_mask, 16'h0000);
    idle(1, 0);
    check("hrst_text_mask", fill_mask, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
